// File: rtl/grng_pkg.sv
// Shared types and width helpers for the GRNG statistics monitor.
package grng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mon_state_t;

    localparam int DROP_W = 16;

    // Signed sum width: one sample plus one bit per doubling of the window.
    function automatic int SUM_W(input int sw, input int lw);
        return sw + lw;
    endfunction

    // Sum-of-squares width: a full-width square plus one bit per doubling.
    function automatic int SQ_W(input int sw, input int lw);
        return 2 * sw + lw;
    endfunction

endpackage

// File: rtl/grng_stat_monitor_if.sv
// Sample stream, control and statistics readout bundle for grng_stat_monitor.
interface grng_stat_monitor_if
    import grng_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int LOG2_WIN = 10
);
    logic                                  start;
    logic                                  continuous;
    logic [SAMPLE_W-1:0]                   sample;
    logic                                  sample_valid;
    logic                                  busy;
    logic                                  result_valid;
    logic                                  result_ready;
    logic [SUM_W(SAMPLE_W, LOG2_WIN)-1:0]  sum_out;
    logic [SQ_W(SAMPLE_W, LOG2_WIN)-1:0]   sumsq_out;
    logic [SAMPLE_W-1:0]                   min_out;
    logic [SAMPLE_W-1:0]                   max_out;
    logic [DROP_W-1:0]                     dropped_out;

    modport master (
        output start, continuous, sample, sample_valid, result_ready,
        input  busy, result_valid, sum_out, sumsq_out, min_out, max_out, dropped_out
    );

    modport slave (
        input  start, continuous, sample, sample_valid, result_ready,
        output busy, result_valid, sum_out, sumsq_out, min_out, max_out, dropped_out
    );

endinterface

// File: rtl/grng_moment_acc.sv
// Running sum, sum of squares, min and max over centred samples.
// The *Next_o outputs include the sample presented this cycle, so the
// owner can capture a finished window on the same edge that accepts
// its last sample.
module grng_moment_acc
    import grng_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int LOG2_WIN = 10
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        clear_i,
    input  logic                                        en_i,
    input  logic signed [SAMPLE_W-1:0]                  x_i,
    output logic signed [SUM_W(SAMPLE_W, LOG2_WIN)-1:0] sumNext_o,
    output logic        [SQ_W(SAMPLE_W, LOG2_WIN)-1:0]  sumsqNext_o,
    output logic signed [SAMPLE_W-1:0]                  minNext_o,
    output logic signed [SAMPLE_W-1:0]                  maxNext_o
);
    localparam int SUM_WL = SUM_W(SAMPLE_W, LOG2_WIN);
    localparam int SQ_WL  = SQ_W(SAMPLE_W, LOG2_WIN);
    localparam logic signed [SAMPLE_W-1:0] POS_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] NEG_MAX = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic signed [SUM_WL-1:0]     sum_q, sum_d;
    logic        [SQ_WL-1:0]      sumsq_q, sumsq_d;
    logic signed [SAMPLE_W-1:0]   min_q, min_d;
    logic signed [SAMPLE_W-1:0]   max_q, max_d;
    logic signed [2*SAMPLE_W-1:0] square;

    // Next moments: clear seeds min/max with the opposite extremes, enable folds in x.
    always_comb begin
        square  = x_i * x_i;
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        min_d   = min_q;
        max_d   = max_q;
        if (clear_i) begin
            sum_d   = '0;
            sumsq_d = '0;
            min_d   = POS_MAX;
            max_d   = NEG_MAX;
        end else if (en_i) begin
            sum_d   = sum_q + {{LOG2_WIN{x_i[SAMPLE_W-1]}}, x_i};
            sumsq_d = sumsq_q + {{LOG2_WIN{1'b0}}, square};
            if (x_i < min_q) min_d = x_i;
            if (x_i > max_q) max_d = x_i;
        end
    end

    // Accumulator registers, zeroed by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            sumsq_q <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

    assign sumNext_o   = sum_d;
    assign sumsqNext_o = sumsq_d;
    assign minNext_o   = min_d;
    assign maxNext_o   = max_d;

endmodule

// File: rtl/grng_stat_monitor.sv
// Window statistics checker for the GRNG sample stream with a valid/ready readout.
module grng_stat_monitor
    import grng_pkg::*;
#(
    parameter int SAMPLE_W      = 8,
    parameter int LOG2_WIN      = 10,
    parameter int OFFSET_BINARY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    grng_stat_monitor_if.slave mon
);
    localparam int SUM_WL = SUM_W(SAMPLE_W, LOG2_WIN);
    localparam int SQ_WL  = SQ_W(SAMPLE_W, LOG2_WIN);
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    mon_state_t state_q, state_d;

    logic                       busy, resultValid, accEn, accClear, windowEnd;
    logic signed [SAMPLE_W-1:0] x;

    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic [DROP_W-1:0]   dropCount_q, dropCount_d;

    logic signed [SUM_WL-1:0]   sumNext;
    logic        [SQ_WL-1:0]    sumsqNext;
    logic signed [SAMPLE_W-1:0] minNext, maxNext;

    logic [SUM_WL-1:0]   sumOut_q, sumOut_d;
    logic [SQ_WL-1:0]    sumsqOut_q, sumsqOut_d;
    logic [SAMPLE_W-1:0] minOut_q, minOut_d;
    logic [SAMPLE_W-1:0] maxOut_q, maxOut_d;
    logic [DROP_W-1:0]   droppedOut_q, droppedOut_d;

    // Centre the sample: flipping the MSB subtracts half-scale from offset-binary.
    always_comb begin
        if (OFFSET_BINARY != 0) x = {~mon.sample[SAMPLE_W-1], mon.sample[SAMPLE_W-2:0]};
        else                    x = mon.sample;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: start only matters in IDLE, ready only in HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mon.start) state_d = ACCUM;
            ACCUM:   if (windowEnd) state_d = HOLD;
            HOLD:    if (mon.result_ready) state_d = mon.continuous ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        busy        = (state_q == ACCUM);
        resultValid = (state_q == HOLD);
        accEn       = busy && mon.sample_valid;
        windowEnd   = accEn && (cnt_q == '1);
        accClear    = ((state_q == IDLE) && mon.start) ||
                      ((state_q == HOLD) && mon.result_ready);
    end

    grng_moment_acc #(
        .SAMPLE_W (SAMPLE_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (accClear),
        .en_i        (accEn),
        .x_i         (x),
        .sumNext_o   (sumNext),
        .sumsqNext_o (sumsqNext),
        .minNext_o   (minNext),
        .maxNext_o   (maxNext)
    );

    // Counter, saturating drop count and report capture; the drop count restarts
    // when a report is captured so HOLD-phase drops land in the following report.
    always_comb begin
        cnt_d        = cnt_q;
        dropCount_d  = dropCount_q;
        sumOut_d     = sumOut_q;
        sumsqOut_d   = sumsqOut_q;
        minOut_d     = minOut_q;
        maxOut_d     = maxOut_q;
        droppedOut_d = droppedOut_q;
        if (accClear)   cnt_d = '0;
        else if (accEn) cnt_d = cnt_q + 1'b1;
        if (windowEnd) begin
            dropCount_d  = '0;
            sumOut_d     = sumNext;
            sumsqOut_d   = sumsqNext;
            minOut_d     = minNext;
            maxOut_d     = maxNext;
            droppedOut_d = dropCount_q;
        end else if (!busy && mon.sample_valid && (dropCount_q != '1)) begin
            dropCount_d = dropCount_q + DROP_ONE;
        end
    end

    // Counter, drop count and report registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dropCount_q  <= '0;
            sumOut_q     <= '0;
            sumsqOut_q   <= '0;
            minOut_q     <= '0;
            maxOut_q     <= '0;
            droppedOut_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            dropCount_q  <= dropCount_d;
            sumOut_q     <= sumOut_d;
            sumsqOut_q   <= sumsqOut_d;
            minOut_q     <= minOut_d;
            maxOut_q     <= maxOut_d;
            droppedOut_q <= droppedOut_d;
        end
    end

    assign mon.busy         = busy;
    assign mon.result_valid = resultValid;
    assign mon.sum_out      = sumOut_q;
    assign mon.sumsq_out    = sumsqOut_q;
    assign mon.min_out      = minOut_q;
    assign mon.max_out      = maxOut_q;
    assign mon.dropped_out  = droppedOut_q;

endmodule

// File: tb/tb_grng_stat_monitor.sv
// Directed bench for grng_stat_monitor: a 4-sample window instance and a
// 1024-sample window instance sharing clock and reset.
module tb_grng_stat_monitor;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    grng_stat_monitor_if #(.SAMPLE_W(8), .LOG2_WIN(2))  ifc2 ();
    grng_stat_monitor_if #(.SAMPLE_W(8), .LOG2_WIN(10)) ifc10 ();

    grng_stat_monitor #(.SAMPLE_W(8), .LOG2_WIN(2), .OFFSET_BINARY(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (ifc2)
    );

    grng_stat_monitor #(.SAMPLE_W(8), .LOG2_WIN(10), .OFFSET_BINARY(1)) dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (ifc10)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] s, input logic v);
        ifc2.sample       = s;
        ifc2.sample_valid = v;
        tick();
    endtask

    task automatic checkReport(input string tag, input longint s, input longint sq,
                               input longint mn, input longint mx, input longint dr);
        checkOutput({tag, ".valid"}, longint'(ifc2.result_valid), 1);
        checkOutput({tag, ".sum"}, longint'($signed(ifc2.sum_out)), s);
        checkOutput({tag, ".sumsq"}, longint'(ifc2.sumsq_out), sq);
        checkOutput({tag, ".min"}, longint'($signed(ifc2.min_out)), mn);
        checkOutput({tag, ".max"}, longint'($signed(ifc2.max_out)), mx);
        checkOutput({tag, ".dropped"}, longint'(ifc2.dropped_out), dr);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".busy"}, longint'(ifc2.busy), 0);
        checkOutput({tag, ".valid"}, longint'(ifc2.result_valid), 0);
        checkOutput({tag, ".sum"}, longint'(ifc2.sum_out), 0);
        checkOutput({tag, ".sumsq"}, longint'(ifc2.sumsq_out), 0);
        checkOutput({tag, ".min"}, longint'(ifc2.min_out), 0);
        checkOutput({tag, ".max"}, longint'(ifc2.max_out), 0);
        checkOutput({tag, ".dropped"}, longint'(ifc2.dropped_out), 0);
    endtask

    task automatic handshake(input logic cont);
        ifc2.result_ready = 1'b1;
        ifc2.continuous   = cont;
        tick();
        ifc2.result_ready = 1'b0;
        ifc2.continuous   = 1'b0;
    endtask

    task automatic startWindow();
        ifc2.start = 1'b1;
        tick();
        ifc2.start = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        ifc2.start = 1'b0;  ifc2.continuous = 1'b0;  ifc2.sample = 8'd0;
        ifc2.sample_valid = 1'b0;  ifc2.result_ready = 1'b0;
        ifc10.start = 1'b0; ifc10.continuous = 1'b0; ifc10.sample = 8'd0;
        ifc10.sample_valid = 1'b0; ifc10.result_ready = 1'b0;

        tick();
        tick();
        checkCleared("reset");
        rst_n = 1'b1;

        // Constant window of mid-scale samples.
        startWindow();
        checkOutput("const.busy", longint'(ifc2.busy), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'd128, 1'b1);
            if (i == 2) checkOutput("const.early", longint'(ifc2.result_valid), 0);
        end
        ifc2.sample_valid = 1'b0;
        checkReport("const", 0, 0, 0, 0, 0);
        checkOutput("const.busyHold", longint'(ifc2.busy), 0);
        handshake(1'b0);
        checkOutput("const.validDrop", longint'(ifc2.result_valid), 0);

        // Mixed values including both offset-binary extremes.
        startWindow();
        applyStimulus(8'd130, 1'b1);
        applyStimulus(8'd126, 1'b1);
        applyStimulus(8'd0,   1'b1);
        applyStimulus(8'd255, 1'b1);
        ifc2.sample_valid = 1'b0;
        checkReport("mixed", -1, 32521, -128, 127, 0);

        // Readout stalled: the report must not move while ready is low.
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("hold.valid", longint'(ifc2.result_valid), 1);
            checkOutput("hold.sum", longint'($signed(ifc2.sum_out)), -1);
        end
        handshake(1'b0);
        checkOutput("hold.validAfter", longint'(ifc2.result_valid), 0);
        checkOutput("hold.busyAfter", longint'(ifc2.busy), 0);
        checkOutput("hold.sumKept", longint'($signed(ifc2.sum_out)), -1);
        checkOutput("hold.sqKept", longint'(ifc2.sumsq_out), 32521);
        checkOutput("hold.minKept", longint'($signed(ifc2.min_out)), -128);

        // Three drops in IDLE, then a gapped window (x = 1, 3, -3, -8).
        applyStimulus(8'd200, 1'b1);
        applyStimulus(8'd0,   1'b0);
        applyStimulus(8'd10,  1'b1);
        applyStimulus(8'd0,   1'b0);
        applyStimulus(8'd50,  1'b1);
        ifc2.sample_valid = 1'b0;
        startWindow();
        applyStimulus(8'd129, 1'b1);
        applyStimulus(8'd255, 1'b0);
        applyStimulus(8'd131, 1'b1);
        applyStimulus(8'd0,   1'b0);
        applyStimulus(8'd0,   1'b0);
        applyStimulus(8'd125, 1'b1);
        applyStimulus(8'd120, 1'b1);
        ifc2.sample_valid = 1'b0;
        checkReport("gapped", -7, 83, -8, 3, 3);

        // Two drops while holding, then continuous restart.
        applyStimulus(8'd77, 1'b1);
        applyStimulus(8'd0,  1'b0);
        applyStimulus(8'd99, 1'b1);
        ifc2.sample_valid = 1'b0;
        handshake(1'b1);
        checkOutput("cont.busy", longint'(ifc2.busy), 1);
        checkOutput("cont.valid", longint'(ifc2.result_valid), 0);
        for (int i = 0; i < 4; i++) applyStimulus(8'd128, 1'b1);
        ifc2.sample_valid = 1'b0;
        checkReport("cont", 0, 0, 0, 0, 2);
        handshake(1'b0);
        checkOutput("cont.idle", longint'(ifc2.busy), 0);

        // Reset halfway through a window discards it and clears the report.
        startWindow();
        applyStimulus(8'd129, 1'b1);
        applyStimulus(8'd129, 1'b1);
        ifc2.sample_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkCleared("midReset");
        startWindow();
        for (int i = 0; i < 4; i++) applyStimulus(8'd129, 1'b1);
        ifc2.sample_valid = 1'b0;
        checkReport("afterReset", 4, 4, 1, 1, 0);

        // Full-scale negative window on the 1024-sample instance.
        ifc10.start = 1'b1;
        tick();
        ifc10.start = 1'b0;
        ifc10.sample = 8'h00;
        ifc10.sample_valid = 1'b1;
        for (int i = 0; i < 1023; i++) tick();
        checkOutput("full.early", longint'(ifc10.result_valid), 0);
        tick();
        ifc10.sample_valid = 1'b0;
        checkOutput("full.valid", longint'(ifc10.result_valid), 1);
        checkOutput("full.sum", longint'($signed(ifc10.sum_out)), -131072);
        checkOutput("full.sumsq", longint'(ifc10.sumsq_out), 16777216);
        checkOutput("full.min", longint'($signed(ifc10.min_out)), -128);
        checkOutput("full.max", longint'($signed(ifc10.max_out)), -128);
        checkOutput("full.dropped", longint'(ifc10.dropped_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
